// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit holding the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   pend_hi_q;
    logic [31:0]   pend_lo_q;
    logic          pend_wr_q;

    logic [63:0]   prod;
    logic          is_signed;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   b_safe;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_wr;

    // Result is computed at launch; the counter only models pipeline latency.
    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & A[31];
        b_neg     = is_signed & B[31];
        if (is_signed)
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        else
            prod = {32'd0, A} * {32'd0, B};
        a_mag  = a_neg ? (~A + 32'd1) : A;
        b_mag  = b_neg ? (~B + 32'd1) : B;
        // Magnitude division makes 0x80000000 / -1 fall out naturally.
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
        if (op[1]) begin
            res_hi = rem;
            res_lo = quot;
            res_wr = (B != 32'd0);
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            HI        <= 32'd0;
            LO        <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        cnt_q     <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        pend_hi_q <= res_hi;
                        pend_lo_q <= res_lo;
                        pend_wr_q <= res_wr;
                    end else begin
                        if (hi_we) HI <= A;
                        if (lo_we) LO <= A;
                    end
                end
                default: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_IDLE;
                        if (pend_wr_q) begin
                            HI <= pend_hi_q;
                            LO <= pend_lo_q;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks;
    int n_fail;
    int cnt;
    int bad;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic lw);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        lo_we = lw;
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int hold_bad;
        prev_hi  = HI;
        prev_lo  = LO;
        hold_bad = 0;
        launch(o, a, b, 1'b0);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (HI !== prev_hi || LO !== prev_lo) hold_bad++;
            A = $urandom;
            B = $urandom;
            @(negedge clk);
        end
        check({tag, "_cycles"}, cnt, exp_cyc);
        check({tag, "_hold"}, hold_bad, 0);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult",  2'b00, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 2'b01, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",   2'b10, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  2'b11, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        // mthi then divide by zero
        @(negedge clk);
        hi_we = 1'b1;
        A     = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", HI, 32'h12345678);
        check("mthi_lo", LO, 32'h80000000);
        run_op("divu0", 2'b11, 32'd5, 32'd0, 10, 32'h12345678, 32'h80000000);

        // mthi + mtlo together
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        A     = 32'hCAFEF00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mtboth_hi", HI, 32'hCAFEF00D);
        check("mtboth_lo", LO, 32'hCAFEF00D);

        // start and mthi attempted while busy
        launch(2'b00, 32'd2, 32'd3, 1'b0);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            start = (cnt == 2);
            op    = 2'b11;
            hi_we = (cnt == 3);
            A     = (cnt == 3) ? 32'hDEAD : 32'd9;
            B     = 32'd4;
            @(negedge clk);
        end
        start = 1'b0;
        hi_we = 1'b0;
        check("intf_cycles", cnt, 5);
        check("intf_hi", HI, 32'd0);
        check("intf_lo", LO, 32'd6);
        @(negedge clk);
        check("intf_idle", {31'd0, busy}, 32'd0);

        // start with mtlo in IDLE: move dropped
        launch(2'b01, 32'd4, 32'd5, 1'b1);
        check("stlo_lo_during", LO, 32'd6);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("stlo_cycles", cnt, 5);
        check("stlo_lo", LO, 32'd20);
        check("stlo_hi", HI, 32'd0);

        // reset during div
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        A     = 32'h55AA55AA;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        launch(2'b10, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rdiv_busy_pre", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rdiv_busy", {31'd0, busy}, 32'd0);
        check("rdiv_hi", HI, 32'd0);
        check("rdiv_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
        end
        check("rdiv_after", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
